// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain loop: Q8.8 width, FSM encoding and default thresholds.
package agc_pkg;

    localparam int Q_W   = 16;
    localparam int ACC_W = 18;

    localparam logic signed [Q_W-1:0] LOCK_THRESH_DEF   = 16'sd32;
    localparam logic signed [Q_W-1:0] UNLOCK_THRESH_DEF = 16'sd128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLD    = 2'd3
    } agc_state_e;

    // Magnitude of a Q8.8 value; the most negative code saturates instead of wrapping.
    function automatic logic [Q_W-1:0] abs_sat(input logic signed [Q_W-1:0] v);
        logic [Q_W-1:0] r;
        if (v == 16'sh8000) begin
            r = 16'h7FFF;
        end else if (v[Q_W-1]) begin
            r = 16'(-v);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/agc_gain_acc.sv
// Combinational gain step: gain + (error >>> mu) in 18-bit signed, clamped to [GAIN_MIN, GAIN_MAX].
module agc_gain_acc
    import agc_pkg::*;
#(
    parameter logic signed [Q_W-1:0] GAIN_MIN = 16'sh0010,
    parameter logic signed [Q_W-1:0] GAIN_MAX = 16'sh7F00
) (
    input  logic signed [Q_W-1:0] gain_i,
    input  logic signed [Q_W-1:0] error_i,
    input  logic        [3:0]     mu_i,
    output logic signed [Q_W-1:0] gain_o
);

    localparam logic signed [ACC_W-1:0] MIN_X = ACC_W'(GAIN_MIN);
    localparam logic signed [ACC_W-1:0] MAX_X = ACC_W'(GAIN_MAX);

    logic signed [Q_W-1:0]   shifted_s;
    logic signed [ACC_W-1:0] step_s;
    logic signed [ACC_W-1:0] sum_s;

    // Widen both operands before the add so the sum can never wrap ahead of the clamp.
    always_comb begin
        shifted_s = error_i >>> mu_i;
        step_s    = {{(ACC_W-Q_W){shifted_s[Q_W-1]}}, shifted_s};
        sum_s     = {{(ACC_W-Q_W){gain_i[Q_W-1]}}, gain_i} + step_s;
        if (sum_s > MAX_X) begin
            gain_o = GAIN_MAX;
        end else if (sum_s < MIN_X) begin
            gain_o = GAIN_MIN;
        end else begin
            gain_o = sum_s[Q_W-1:0];
        end
    end

endmodule

// File: rtl/agc_gain_loop.sv
// AGC loop controller: IDLE/ACQUIRE/TRACK/HOLD FSM, lock/miss counters and the registered gain.
module agc_gain_loop
    import agc_pkg::*;
#(
    parameter int                    MU_SHIFT_ACQ  = 4,
    parameter int                    MU_SHIFT_TRK  = 7,
    parameter logic signed [Q_W-1:0] GAIN_INIT     = 16'sh0100,
    parameter logic signed [Q_W-1:0] GAIN_MIN      = 16'sh0010,
    parameter logic signed [Q_W-1:0] GAIN_MAX      = 16'sh7F00,
    parameter logic signed [Q_W-1:0] LOCK_THRESH   = LOCK_THRESH_DEF,
    parameter logic signed [Q_W-1:0] UNLOCK_THRESH = UNLOCK_THRESH_DEF,
    parameter int                    LOCK_COUNT    = 16,
    parameter int                    UNLOCK_COUNT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  hold,
    input  logic                  error_valid,
    input  logic signed [Q_W-1:0] error,
    output logic signed [Q_W-1:0] gain,
    output logic                  gain_valid,
    output logic                  locked,
    output logic [1:0]            state
);

    agc_state_e            state_q, state_d;
    agc_state_e            prev_q, prev_d;
    logic [15:0]           lock_cnt_q, lock_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;
    logic signed [Q_W-1:0] gain_q, gain_d;
    logic                  gain_valid_q, gain_valid_d;
    logic                  locked_q, locked_d;

    logic [3:0]            mu_s;
    logic signed [Q_W-1:0] acc_gain_s;
    logic [Q_W-1:0]        mag_s;
    logic [16:0]           lock_inc_s;
    logic [16:0]           miss_inc_s;

    agc_gain_acc #(
        .GAIN_MIN (GAIN_MIN),
        .GAIN_MAX (GAIN_MAX)
    ) u_acc (
        .gain_i  (gain_q),
        .error_i (error),
        .mu_i    (mu_s),
        .gain_o  (acc_gain_s)
    );

    // Step size and counter increments derived from the current state and sample.
    always_comb begin
        if (state_q == ST_TRACK) begin
            mu_s = 4'(MU_SHIFT_TRK);
        end else begin
            mu_s = 4'(MU_SHIFT_ACQ);
        end
        mag_s      = abs_sat(error);
        lock_inc_s = {1'b0, lock_cnt_q} + 17'd1;
        miss_inc_s = {1'b0, miss_cnt_q} + 17'd1;
    end

    // Next-state logic: enable beats hold, hold beats the update.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        lock_cnt_d   = lock_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        gain_d       = gain_q;
        gain_valid_d = 1'b0;
        if (!enable) begin
            state_d    = ST_IDLE;
            lock_cnt_d = 16'd0;
            miss_cnt_d = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (hold) begin
                        state_d = ST_HOLD;
                        prev_d  = ST_ACQUIRE;
                    end else if (error_valid) begin
                        gain_d       = acc_gain_s;
                        gain_valid_d = 1'b1;
                        if (mag_s <= $unsigned(LOCK_THRESH)) begin
                            if (lock_inc_s >= 17'(LOCK_COUNT)) begin
                                state_d    = ST_TRACK;
                                lock_cnt_d = 16'd0;
                            end else begin
                                lock_cnt_d = lock_inc_s[15:0];
                            end
                        end else begin
                            lock_cnt_d = 16'd0;
                        end
                    end else begin
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_TRACK: begin
                    if (hold) begin
                        state_d = ST_HOLD;
                        prev_d  = ST_TRACK;
                    end else if (error_valid) begin
                        gain_d       = acc_gain_s;
                        gain_valid_d = 1'b1;
                        if (mag_s > $unsigned(UNLOCK_THRESH)) begin
                            if (miss_inc_s >= 17'(UNLOCK_COUNT)) begin
                                state_d    = ST_ACQUIRE;
                                miss_cnt_d = 16'd0;
                            end else begin
                                miss_cnt_d = miss_inc_s[15:0];
                            end
                        end else begin
                            miss_cnt_d = 16'd0;
                        end
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                ST_HOLD: begin
                    if (!hold) begin
                        state_d = prev_q;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        locked_d = (state_d == ST_TRACK) || ((state_d == ST_HOLD) && (prev_d == ST_TRACK));
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= ST_IDLE;
            lock_cnt_q   <= 16'd0;
            miss_cnt_q   <= 16'd0;
            gain_q       <= GAIN_INIT;
            gain_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            lock_cnt_q   <= lock_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            gain_q       <= gain_d;
            gain_valid_q <= gain_valid_d;
            locked_q     <= locked_d;
        end
    end

    assign gain       = gain_q;
    assign gain_valid = gain_valid_q;
    assign locked     = locked_q;
    assign state      = state_q;

endmodule

// File: tb/tb_agc_gain_loop.sv
// Self-checking bench for agc_gain_loop: directed table, corner-case sequences, randomized run against a model.
module tb_agc_gain_loop;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               hold = 1'b0;
    logic               error_valid = 1'b0;
    logic signed [15:0] err_s = 16'sd0;
    logic signed [15:0] gain_s;
    logic               gain_valid_s;
    logic               locked_s;
    logic [1:0]         state_s;

    int vectors = 0;
    int miscompares = 0;

    agc_gain_loop dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .hold        (hold),
        .error_valid (error_valid),
        .error       (err_s),
        .gain        (gain_s),
        .gain_valid  (gain_valid_s),
        .locked      (locked_s),
        .state       (state_s)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, modes 0..3 = idle/acquire/track/hold.
    int m_mode, m_prev, m_lock, m_miss, m_gain, m_gv, m_locked;

    task automatic model_step(input bit r, input bit en, input bit h, input bit ev, input int e);
        int mag, ng;
        if (r) begin
            m_mode = 0; m_prev = 0; m_lock = 0; m_miss = 0;
            m_gain = 256; m_gv = 0; m_locked = 0;
            return;
        end
        m_gv = 0;
        if (!en) begin
            m_mode = 0; m_lock = 0; m_miss = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 3) begin
            if (!h) m_mode = m_prev;
        end else if (h) begin
            m_prev = m_mode;
            m_mode = 3;
        end else if (ev) begin
            ng = m_gain + (e >>> ((m_mode == 2) ? 7 : 4));
            if (ng > 32512) ng = 32512;
            if (ng < 16) ng = 16;
            m_gain = ng;
            m_gv = 1;
            mag = (e < 0) ? -e : e;
            if (mag > 32767) mag = 32767;
            if (m_mode == 1) begin
                if (mag <= 32) begin
                    m_lock++;
                    if (m_lock >= 16) begin m_lock = 0; m_mode = 2; end
                end else m_lock = 0;
            end else begin
                if (mag > 128) begin
                    m_miss++;
                    if (m_miss >= 4) begin m_miss = 0; m_mode = 1; end
                end else m_miss = 0;
            end
        end
        m_locked = (m_mode == 2 || (m_mode == 3 && m_prev == 2)) ? 1 : 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, step the model at the rising edge, return at the next falling edge.
    task automatic drive(input bit r, input bit en, input bit h, input bit ev, input logic signed [15:0] e);
        rst = r; enable = en; hold = h; error_valid = ev; err_s = e;
        @(posedge clk);
        model_step(r, en, h, ev, int'(e));
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input int st, input int g, input int gv, input int lk);
        chk({tag, "_state"}, int'(state_s), st);
        chk({tag, "_gain"}, int'(gain_s), g);
        chk({tag, "_gv"}, int'(gain_valid_s), gv);
        chk({tag, "_locked"}, int'(locked_s), lk);
    endtask

    typedef struct {
        bit                 en;
        bit                 h;
        bit                 ev;
        logic signed [15:0] e;
        int                 st;
        int                 g;
        int                 gv;
        int                 lk;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'sh0000, 1, 32'h0100, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 16'sh0100, 1, 32'h0110, 1, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'sh0000, 1, 32'h0110, 0, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'sh8000, 1, 32'h0010, 1, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 16'sh7FFF, 1, 32'h080F, 1, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 16'sh0100, 3, 32'h080F, 0, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 16'sh0000, 1, 32'h080F, 0, 0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 16'sh0100, 0, 32'h080F, 0, 0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 16'sh0100, 1, 32'h080F, 0, 0};

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sh0000);
        chk_out("reset", 0, 32'h0100, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, tbl[i].en, tbl[i].h, tbl[i].ev, tbl[i].e);
            chk_out($sformatf("tbl%0d", i), tbl[i].st, tbl[i].g, tbl[i].gv, tbl[i].lk);
        end

        // Lock after 16 small errors, then a TRACK-rate step.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sh0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'sh0000);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh0010);
            if (i == 15) chk_out("lock15", 1, 32'h010F, 1, 0);
        end
        chk_out("lock16", 2, 32'h0110, 1, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh0080);
        chk_out("trk_step", 2, 32'h0111, 1, 1);

        // Three misses then a good sample keeps TRACK; four misses drop to ACQUIRE.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh0200);
        chk_out("miss3", 2, 32'h011D, 1, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh0000);
        chk_out("miss_clr", 2, 32'h011D, 1, 1);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh0200);
            if (i == 3) chk("miss3b_state", int'(state_s), 2);
        end
        chk_out("unlock", 1, 32'h012D, 1, 0);

        // Upper clamp from 0x7EF8, then lower clamp under repeated -32768.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sh0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'sh0000);
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh7FFF);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh6070);
        chk("pre_clamp_gain", int'(gain_s), 32'h7EF8);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh7FFF);
        chk_out("clamp_hi", 1, 32'h7F00, 1, 0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh8000);
        chk_out("clamp_lo", 1, 32'h0010, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh8000);
        chk_out("clamp_lo_pulse", 1, 32'h0010, 1, 0);

        // Hold precedence in TRACK, enable over hold, reset while held.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sh0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'sh0000);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh0000);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'sh0100);
        chk_out("hold_trk", 3, 32'h0100, 0, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'sh0000);
        chk_out("hold_rel", 2, 32'h0100, 0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'sh0100);
        chk_out("en_over_hold", 0, 32'h0100, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'sh0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'sh0100);
        chk("pre_rst_gain", int'(gain_s), 32'h0110);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'sh0000);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'sh0100);
        chk_out("rst_mid", 0, 32'h0100, 0, 0);

        // Randomized run in bursts biased toward locking and unlocking.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'sh0000);
        for (int c = 0; c < 4000; c++) begin
            bit r, en, h, ev;
            int ph, e;
            ph = (c / 80) % 3;
            r  = ($urandom_range(999) < 2);
            en = ($urandom_range(99) < 97);
            h  = ($urandom_range(99) < ((ph == 2) ? 15 : 3));
            ev = ($urandom_range(99) < 85);
            case (ph)
                0:       e = $urandom_range(80) - 40;
                1:       e = (($urandom_range(1) == 1) ? 1 : -1) * int'($urandom_range(2000, 100));
                default: e = int'($urandom_range(65535)) - 32768;
            endcase
            drive(r, en, h, ev, 16'(e));
            chk_out("rand", m_mode, m_gain, m_gv, m_locked);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
